seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle successor to the team's 8-bit combinational ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a register.
- Uses a start/ready/done handshake with registered results and carry and signed-overflow flags.
- Sits in the lab datapath as the shared ALU add/sub unit, trading latency for a short critical path.

---
 rtl/seq_chunk_adder.sv | 113 +++++++++++
 tb/tb_seq_chunk_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub, CHUNK bits per clock.
// Ports: clk, rst_n, start/a/b/c_in/sub in; ready/busy/done, sum/c_out/ovf out.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  part_r;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic              accept;
    logic              last;
    logic [CHUNK:0]    add;
    logic [WIDTH-1:0]  p_ext;
    logic [WIDTH-1:0]  part_nx;
    logic              ovf_nx;

    assign accept = start & (state != S_RUN);
    assign last   = (idx == IDXW'(NCHUNK - 1));

    // Operands shift right each cycle so the active chunk is always
    // the low CHUNK bits; finished chunks enter the shadow from the top.
    assign add = {1'b0, a_r[CHUNK-1:0]}
               + {1'b0, b_r[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry};

    assign p_ext   = WIDTH'(add[CHUNK-1:0]) << (WIDTH - CHUNK);
    assign part_nx = p_ext | (part_r >> CHUNK);

    // Carry into the MSB recovered from the MSB sum bit.
    assign ovf_nx = a_r[CHUNK-1] ^ b_r[CHUNK-1]
                  ^ add[CHUNK-1] ^ add[CHUNK];

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start) state_nx = S_RUN;
            S_RUN:  if (last)  state_nx = S_DONE;
            S_DONE: state_nx = start ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            part_r <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_r    <= a;
            b_r    <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : c_in;
            idx    <= '0;
        end else if (state == S_RUN) begin
            a_r    <= a_r >> CHUNK;
            b_r    <= b_r >> CHUNK;
            part_r <= part_nx;
            carry  <= add[CHUNK];
            idx    <= idx + IDXW'(1);
            if (last) begin
                sum   <= part_nx;
                c_out <= add[CHUNK];
                ovf   <= ovf_nx;
            end
        end
    end

    assign ready = (state != S_RUN);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed checks of seq_chunk_adder in three
// configurations (8/4, 32/8, 8/8).
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 32-bit, 8-bit chunks
    logic        st32 = 0, ci32 = 0, sb32 = 0;
    logic [31:0] a32 = 0, b32 = 0, sum32;
    logic        rdy32, bsy32, dn32, co32, ov32;

    // 8-bit, 4-bit chunks
    logic        st84 = 0, ci84 = 0, sb84 = 0;
    logic [7:0]  a84 = 0, b84 = 0, sum84;
    logic        rdy84, bsy84, dn84, co84, ov84;

    // 8-bit, single chunk
    logic        st88 = 0, ci88 = 0, sb88 = 0;
    logic [7:0]  a88 = 0, b88 = 0, sum88;
    logic        rdy88, bsy88, dn88, co88, ov88;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .a(a32), .b(b32),
        .c_in(ci32), .sub(sb32), .ready(rdy32), .busy(bsy32),
        .done(dn32), .sum(sum32), .c_out(co32), .ovf(ov32)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u84 (
        .clk(clk), .rst_n(rst_n), .start(st84), .a(a84), .b(b84),
        .c_in(ci84), .sub(sb84), .ready(rdy84), .busy(bsy84),
        .done(dn84), .sum(sum84), .c_out(co84), .ovf(ov84)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u88 (
        .clk(clk), .rst_n(rst_n), .start(st88), .a(a88), .b(b88),
        .c_in(ci88), .sub(sb88), .ready(rdy88), .busy(bsy88),
        .done(dn88), .sum(sum88), .c_out(co88), .ovf(ov88)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    // Pulse start on the 32-bit unit and wait for done.
    task automatic op32(input vec_t v, output int lat);
        @(negedge clk);
        a32 = v.a; b32 = v.b; ci32 = v.ci; sb32 = v.sb; st32 = 1;
        @(posedge clk); #1;
        st32 = 0;
        a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; sb32 = ~v.sb;
        lat = 0;
        while (!dn32 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int cyc;
        int dn_seen;
        logic [32:0] wide;
        logic [31:0] ba[3];
        logic [31:0] bb[3];

        vecs[0] = '{32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1};
        vecs[2] = '{32'h5, 32'h7, 0, 1, 32'hFFFF_FFFE, 0, 0};
        vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1, 0,
                    32'h2345_678A, 0, 0};
        vecs[4] = '{32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1};
        vecs[5] = '{32'h7, 32'h5, 1, 1, 32'h2, 1, 0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0, 1, 1};
        vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 0, 0,
                    32'h0100_0100, 0, 0};

        // Reset state
        #12;
        chk("rst_sum32", sum32, 32'h0);
        chk("rst_flags32", {29'b0, co32, ov32, dn32}, 32'h0);
        chk("rst_rdy32", {30'b0, rdy32, bsy32}, 32'h2);
        chk("rst_sum84", {24'b0, sum84}, 32'h0);
        @(negedge clk);
        rst_n = 1;

        // 8/4: 2+3
        @(negedge clk);
        a84 = 8'd2; b84 = 8'd3; st84 = 1;
        @(posedge clk); #1;
        st84 = 0;
        chk("w8c4_rdy_e1", {31'b0, rdy84}, 32'h0);
        chk("w8c4_bsy_e1", {31'b0, bsy84}, 32'h1);
        @(posedge clk); #1;
        chk("w8c4_rdy_e2", {31'b0, rdy84}, 32'h0);
        chk("w8c4_dn_e2", {31'b0, dn84}, 32'h0);
        @(posedge clk); #1;
        chk("w8c4_done", {31'b0, dn84}, 32'h1);
        chk("w8c4_sum", {24'b0, sum84}, 32'h5);
        chk("w8c4_flags", {30'b0, co84, ov84}, 32'h0);
        @(posedge clk); #1;
        chk("w8c4_pulse", {31'b0, dn84}, 32'h0);

        // 8/8: 200+100+1, latency 1
        @(negedge clk);
        a88 = 8'd200; b88 = 8'd100; ci88 = 1; st88 = 1;
        @(posedge clk); #1;
        st88 = 0;
        chk("w8c8_dn_e0", {31'b0, dn88}, 32'h0);
        @(posedge clk); #1;
        chk("w8c8_done", {31'b0, dn88}, 32'h1);
        chk("w8c8_sum", {24'b0, sum88}, 32'h2D);
        chk("w8c8_flags", {30'b0, co88, ov88}, 32'h2);

        // 32/8 table
        for (int i = 0; i < 8; i++) begin
            op32(vecs[i], lat);
            chk($sformatf("v%0d_lat", i), lat, 32'd4);
            chk($sformatf("v%0d_sum", i), sum32, vecs[i].sum);
            chk($sformatf("v%0d_co", i), {31'b0, co32},
                {31'b0, vecs[i].co});
            chk($sformatf("v%0d_ov", i), {31'b0, ov32},
                {31'b0, vecs[i].ov});
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), {31'b0, dn32}, 32'h0);
        end

        // Back-to-back with start held high
        ba[0] = 32'h0000_00FF; bb[0] = 32'h0000_0001;
        ba[1] = 32'hA5A5_A5A5; bb[1] = 32'h5A5A_5A5B;
        ba[2] = 32'h0123_4567; bb[2] = 32'h89AB_CDEF;
        @(negedge clk);
        a32 = ba[0]; b32 = bb[0]; ci32 = 0; sb32 = 0; st32 = 1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            a32 = 32'hFFFF_0000; b32 = 32'h0F0F_0F0F; sb32 = 1;
            cyc = 0;
            while (!dn32 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("b2b%0d_lat", k), cyc, 32'd4);
            wide = {1'b0, ba[k]} + {1'b0, bb[k]};
            chk($sformatf("b2b%0d_sum", k), sum32, wide[31:0]);
            chk($sformatf("b2b%0d_co", k), {31'b0, co32},
                {31'b0, wide[32]});
            sb32 = 0;
            if (k < 2) begin
                a32 = ba[k+1]; b32 = bb[k+1];
            end else begin
                st32 = 0;
            end
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_next_bsy", k), {31'b0, bsy32},
                (k < 2) ? 32'h1 : 32'h0);
        end

        // Reset two cycles into RUN
        @(negedge clk);
        a32 = 32'h1111_1111; b32 = 32'h2222_2222; st32 = 1;
        @(posedge clk); #1;
        st32 = 0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("mid_sum_before", {31'b0, sum32 != 0}, 32'h1);
        rst_n = 0;
        #1;
        chk("mid_rst_sum", sum32, 32'h0);
        chk("mid_rst_st", {28'b0, rdy32, bsy32, dn32, co32}, 32'h8);
        dn_seen = 0;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (dn32) dn_seen++;
        end
        @(negedge clk);
        rst_n = 1;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (dn32) dn_seen++;
        end
        chk("mid_no_done", dn_seen, 32'd0);
        chk("mid_sum_held", sum32, 32'h0);
        op32(vecs[3], lat);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_sum", sum32, vecs[3].sum);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
